// File: rtl/signmag_serial_decoder.sv
// Bit-serial two's-complement to sign-magnitude decoder.
// Scans the operand LSB-first, copying bits up to the first one and inverting the rest.
module signmag_serial_decoder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [WIDTH-1:0] i_in_data,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic             o_out_sign,
  output logic [WIDTH-1:0] o_out_mag,
  output logic             o_out_ovf,
  output logic [1:0]       o_dbg_state
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; valid holds its payload stable until that edge, and ready never
  // depends combinationally on the partner's valid.

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0]    CNT_LAST = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] MAG_MIN  = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_shift;
  logic [WIDTH-1:0] r_acc;
  logic [CW-1:0]    r_cnt;
  logic             r_seen_one;
  logic             r_sign;
  logic             r_out_valid;
  logic             r_out_sign;
  logic [WIDTH-1:0] r_out_mag;
  logic             r_out_ovf;

  logic             w_bit;
  logic             w_mag_bit;
  logic [WIDTH-1:0] w_acc_next;
  logic             w_ovf_next;

  assign w_bit      = r_shift[0];
  // Negative operands invert every bit above the lowest set bit.
  assign w_mag_bit  = (r_sign && r_seen_one) ? ~w_bit : w_bit;
  assign w_acc_next = {w_mag_bit, r_acc[WIDTH-1:1]};
  assign w_ovf_next = r_sign && (w_acc_next == MAG_MIN);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_shift     <= '0;
      r_acc       <= '0;
      r_cnt       <= '0;
      r_seen_one  <= 1'b0;
      r_sign      <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_sign  <= 1'b0;
      r_out_mag   <= '0;
      r_out_ovf   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (i_in_valid) begin
            r_shift    <= i_in_data;
            r_sign     <= i_in_data[WIDTH-1];
            r_cnt      <= '0;
            r_seen_one <= 1'b0;
            r_acc      <= '0;
            r_state    <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          r_acc      <= w_acc_next;
          r_seen_one <= r_seen_one | w_bit;
          r_shift    <= {1'b0, r_shift[WIDTH-1:1]};
          r_cnt      <= r_cnt + 1'b1;
          if (r_cnt == CNT_LAST) begin
            r_state     <= ST_DONE;
            r_out_valid <= 1'b1;
            r_out_sign  <= r_sign;
            r_out_mag   <= w_acc_next;
            r_out_ovf   <= w_ovf_next;
          end
        end
        ST_DONE: begin
          if (i_out_ready) begin
            r_state     <= ST_IDLE;
            r_out_valid <= 1'b0;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign o_in_ready  = (r_state == ST_IDLE);
  assign o_out_valid = r_out_valid;
  assign o_out_sign  = r_out_sign;
  assign o_out_mag   = r_out_mag;
  assign o_out_ovf   = r_out_ovf;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_signmag_serial_decoder.sv
// Self-checking bench for signmag_serial_decoder: directed literal vectors,
// a signed-arithmetic reference model, and a randomly backpressured stream.
module tb_signmag_serial_decoder;

  logic       clk;
  logic       rst_n;
  logic       i_in_valid;
  logic       o_in_ready;
  logic [7:0] i_in_data;
  logic       o_out_valid;
  logic       i_out_ready;
  logic       o_out_sign;
  logic [7:0] o_out_mag;
  logic       o_out_ovf;
  logic [1:0] o_dbg_state;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int last_acc_cyc;
  bit have_last = 0;
  bit prev_ov   = 0;
  bit stream_done = 0;

  logic [7:0] exp_q[$];
  int         acc_cyc_q[$];

  signmag_serial_decoder #(.WIDTH(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_in_valid  (i_in_valid),
    .o_in_ready  (o_in_ready),
    .i_in_data   (i_in_data),
    .o_out_valid (o_out_valid),
    .i_out_ready (i_out_ready),
    .o_out_sign  (o_out_sign),
    .o_out_mag   (o_out_mag),
    .o_out_ovf   (o_out_ovf),
    .o_dbg_state (o_dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    repeat (50000) @(posedge clk);
    $display("FAIL watchdog: cycle budget exhausted, got timeout expected completion");
    $fatal(1);
  end

  // reference model: magnitude and sign from the signed value
  function automatic int ref_value(input logic [7:0] x);
    return x[7] ? int'(x) - 256 : int'(x);
  endfunction

  function automatic logic [7:0] ref_mag(input logic [7:0] x);
    int v;
    v = ref_value(x);
    if (v < 0) v = -v;
    return 8'(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // scoreboard bookkeeping on the active edge
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (!rst_n) begin
      exp_q.delete();
      acc_cyc_q.delete();
      have_last = 0;
    end else begin
      if (o_out_valid && i_out_ready && exp_q.size() > 0) begin
        void'(exp_q.pop_front());
        void'(acc_cyc_q.pop_front());
      end
      if (i_in_valid && o_in_ready) begin
        if (have_last) chk("accept_spacing_ge_10", 32'((cyc - last_acc_cyc) >= 10), 32'd1);
        exp_q.push_back(i_in_data);
        acc_cyc_q.push_back(cyc);
        last_acc_cyc = cyc;
        have_last = 1;
      end
    end
  end

  // compare process: every cycle the result is presented
  always @(negedge clk) begin
    if (rst_n && o_out_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_out_valid", 32'd1, 32'd0);
      end else begin
        chk("model_sign", 32'(o_out_sign), 32'(exp_q[0][7]));
        chk("model_mag",  32'(o_out_mag),  32'(ref_mag(exp_q[0])));
        chk("model_ovf",  32'(o_out_ovf),  32'(ref_value(exp_q[0]) == -128));
        chk("in_ready_low_while_valid", 32'(o_in_ready), 32'd0);
        if (!prev_ov) chk("latency", 32'(cyc - acc_cyc_q[0]), 32'd8);
      end
    end
    prev_ov = o_out_valid;
  end

  // driver tasks
  task automatic send(input logic [7:0] d);
    int t = 0;
    @(negedge clk);
    i_in_valid = 1'b1;
    i_in_data  = d;
    while (!o_in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) chk("in_ready_timeout", 32'd0, 32'd1);
    @(posedge clk);
    #1;
    i_in_valid = 1'b0;
  endtask

  task automatic wait_valid();
    int t = 0;
    while (!o_out_valid && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) chk("out_valid_timeout", 32'd0, 32'd1);
  endtask

  task automatic directed(input logic [7:0] d, input logic s, input logic [7:0] m, input logic o);
    send(d);
    wait_valid();
    chk($sformatf("lit_sign_%02h", d), 32'(o_out_sign), 32'(s));
    chk($sformatf("lit_mag_%02h", d),  32'(o_out_mag),  32'(m));
    chk($sformatf("lit_ovf_%02h", d),  32'(o_out_ovf),  32'(o));
  endtask

  initial begin
    int t;
    rst_n       = 1'b0;
    i_in_valid  = 1'b0;
    i_in_data   = 8'h00;
    i_out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_out_valid", 32'(o_out_valid), 32'd0);
    chk("reset_in_ready",  32'(o_in_ready),  32'd1);
    chk("reset_out_mag",   32'(o_out_mag),   32'd0);
    chk("reset_out_sign",  32'(o_out_sign),  32'd0);
    chk("reset_out_ovf",   32'(o_out_ovf),   32'd0);
    chk("reset_state",     32'(o_dbg_state), 32'd0);
    rst_n = 1'b1;

    // basic and boundary operands
    directed(8'h05, 1'b0, 8'h05, 1'b0);
    directed(8'hFB, 1'b1, 8'h05, 1'b0);
    directed(8'h00, 1'b0, 8'h00, 1'b0);
    directed(8'hFF, 1'b1, 8'h01, 1'b0);
    directed(8'h7F, 1'b0, 8'h7F, 1'b0);
    directed(8'h80, 1'b1, 8'h80, 1'b1);
    directed(8'h81, 1'b1, 8'h7F, 1'b0);

    // backpressure on 0xC0
    @(negedge clk);
    i_out_ready = 1'b0;
    send(8'hC0);
    wait_valid();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("bp_valid_held", 32'(o_out_valid), 32'd1);
      chk("bp_sign",       32'(o_out_sign),  32'd1);
      chk("bp_mag",        32'(o_out_mag),   32'h40);
      chk("bp_in_ready",   32'(o_in_ready),  32'd0);
    end
    i_out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_release_in_ready",  32'(o_in_ready),  32'd1);
    chk("bp_release_out_valid", 32'(o_out_valid), 32'd0);

    // inputs toggled during SHIFT and DONE must not disturb 0x9C
    send(8'h9C);
    t = 0;
    while (!o_out_valid && t < 50) begin
      @(negedge clk);
      if (!o_out_valid) begin
        i_in_valid = 1'($urandom_range(0, 1));
        i_in_data  = 8'($urandom_range(0, 255));
      end
      t++;
    end
    i_out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      i_in_valid = 1'($urandom_range(0, 1));
      i_in_data  = 8'($urandom_range(0, 255));
      chk("ign_sign", 32'(o_out_sign), 32'd1);
      chk("ign_mag",  32'(o_out_mag),  32'h64);
      @(negedge clk);
    end
    i_in_valid  = 1'b0;
    i_out_ready = 1'b1;
    @(posedge clk);

    // asynchronous reset with the counter at 3 while decoding 0xF0
    send(8'hF0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_out_valid", 32'(o_out_valid), 32'd0);
    chk("rst_mid_out_mag",   32'(o_out_mag),   32'd0);
    chk("rst_mid_in_ready",  32'(o_in_ready),  32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    directed(8'h10, 1'b0, 8'h10, 1'b0);

    // random stream with random backpressure
    fork
      begin
        for (int k = 0; k < 256; k++) send(8'($urandom_range(0, 255)));
        stream_done = 1;
      end
      begin
        while (!stream_done) begin
          @(negedge clk);
          i_out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    i_out_ready = 1'b1;
    t = 0;
    while (exp_q.size() > 0 && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("drain_queue_empty", 32'(exp_q.size()), 32'd0);

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
